id_stage_pl: RTL

Parametrised RISC-V instruction-decode pipeline stage. It sits between fetch and execute and contains the control decoder, immediate generator and register file. It uses a valid/ready handshake on both sides. Beyond a plain decode register, it adds flush, load-use hazard stall, write-through register bypass, an XLEN/register-count generalisation and illegal-instruction flagging.

---
 rtl/id_stage_pl_if.sv | 63 ++++++
 rtl/id_stage_pl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pl_if.sv
// -----------------------------------------------------------------------------
// id_stage_pl_if
// Bundle of all signals between fetch, write-back, execute and the decode
// stage id_stage_pl. clk/rst are kept outside the bundle.
//
// Fetch side     : in_valid, in_ready, instruction[31:0], pc[XLEN-1:0], flush
// Write-back side: reg_write, wr_reg[4:0], write_back_data[XLEN-1:0]
// Execute side   : out_valid, out_ready, reg1_data, reg2_data, rs1, rs2, rd,
//                  pc_out, write_back, mem_wr, mem_rd, alu_src, alu_op[3:0],
//                  immediate, illegal
//
// Modports:
//   slave  - the decode stage itself
//   master - the environment around it (fetch / write-back / execute)
// -----------------------------------------------------------------------------
interface id_stage_pl_if #(
  parameter int XLEN = 32
);
  // fetch
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            flush;
  // write-back
  logic            reg_write;
  logic [4:0]      wr_reg;
  logic [XLEN-1:0] write_back_data;
  // execute
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] reg1_data;
  logic [XLEN-1:0] reg2_data;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] pc_out;
  logic            write_back;
  logic            mem_wr;
  logic            mem_rd;
  logic            alu_src;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] immediate;
  logic            illegal;

  modport slave (
    input  in_valid, instruction, pc, flush,
    input  reg_write, wr_reg, write_back_data,
    input  out_ready,
    output in_ready,
    output out_valid, reg1_data, reg2_data, rs1, rs2, rd, pc_out,
    output write_back, mem_wr, mem_rd, alu_src, alu_op, immediate, illegal
  );

  modport master (
    output in_valid, instruction, pc, flush,
    output reg_write, wr_reg, write_back_data,
    output out_ready,
    input  in_ready,
    input  out_valid, reg1_data, reg2_data, rs1, rs2, rd, pc_out,
    input  write_back, mem_wr, mem_rd, alu_src, alu_op, immediate, illegal
  );
endinterface

// File: rtl/id_stage_pl.sv
// -----------------------------------------------------------------------------
// id_stage_pl
// RISC-V instruction-decode pipeline stage: control decoder, immediate
// generator and register file, with a single output register (the decode
// slot) handshaked by valid/ready on both sides.
//
// Features: flush of slot and incoming instruction, one-bubble load-use stall,
// write-through bypass of the write-back port into the operand read,
// XLEN 32/64 and NREG 32/16, illegal opcode / register-index flagging.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (clears slot and register file)
//   bus  - id_stage_pl_if.slave, carries every fetch / write-back / execute
//          signal (see id_stage_pl_if for the list)
//
// Parameters:
//   XLEN - datapath width, 32 or 64
//   NREG - architectural register count, 32 or 16
// -----------------------------------------------------------------------------
module id_stage_pl #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst,
  id_stage_pl_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int         IDXW   = $clog2(NREG);
  localparam logic [5:0] NREG_W = 6'(NREG);

  function automatic logic out_of_range(input logic [4:0] idx);
    return {1'b0, idx} >= NREG_W;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [4:0]  rs1_in;
  logic [4:0]  rs2_in;
  logic [4:0]  rd_in;

  assign instr     = bus.instruction;
  assign opcode    = instr[6:0];
  assign rd_in     = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1_in    = instr[19:15];
  assign rs2_in    = instr[24:20];
  assign funct7_b5 = instr[30];

  // ---------------------------------------------------------------------------
  // Control decode and immediate generation
  // ---------------------------------------------------------------------------
  logic            dec_wb;
  logic            dec_mw;
  logic            dec_mr;
  logic            dec_as;
  logic [3:0]      dec_op;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic            rs1_used;
  logic            rs2_used;
  logic            rd_used;
  logic            op_bad;

  always_comb begin
    dec_wb   = 1'b0;
    dec_mw   = 1'b0;
    dec_mr   = 1'b0;
    dec_as   = 1'b0;
    dec_op   = 4'b0000;
    dec_imm  = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_used  = 1'b0;
    op_bad   = 1'b0;
    case (opcode)
      OP_R: begin
        dec_wb   = 1'b1;
        dec_op   = {funct7_b5, funct3};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        rd_used  = 1'b1;
      end
      OP_IALU: begin
        dec_wb   = 1'b1;
        dec_as   = 1'b1;
        // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is imm.
        dec_op   = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
        dec_imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
        rs1_used = 1'b1;
        rd_used  = 1'b1;
      end
      OP_LOAD: begin
        dec_wb   = 1'b1;
        dec_mr   = 1'b1;
        dec_as   = 1'b1;
        dec_imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
        rs1_used = 1'b1;
        rd_used  = 1'b1;
      end
      OP_STORE: begin
        dec_mw   = 1'b1;
        dec_as   = 1'b1;
        dec_imm  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        dec_op   = 4'b1000;
        dec_imm  = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: op_bad = 1'b1;
    endcase

    // Only fields the format actually uses can make the index illegal; an
    // I-type immediate overlapping rs2 must not trip the RV32E check.
    dec_ill = op_bad
            | (rs1_used & out_of_range(rs1_in))
            | (rs2_used & out_of_range(rs2_in))
            | (rd_used  & out_of_range(rd_in));

    if (dec_ill) begin
      dec_wb = 1'b0;
      dec_mw = 1'b0;
      dec_mr = 1'b0;
      dec_as = 1'b0;
      dec_op = 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file (x0 hard-wired to zero, cleared by reset)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf_word [NREG];
  logic            rf_we;

  assign rf_we = bus.reg_write && (bus.wr_reg != 5'd0) && !out_of_range(bus.wr_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf_word[gi] = '0;
      end else begin : g_reg
        logic [XLEN-1:0] q_reg;
        always_ff @(posedge clk) begin
          if (rst) begin
            q_reg <= '0;
          end else if (rf_we && (bus.wr_reg == 5'(gi))) begin
            q_reg <= bus.write_back_data;
          end
        end
        assign rf_word[gi] = q_reg;
      end
    end
  endgenerate

  // Operand read with write-through: a same-cycle write-back to the source
  // register is forwarded so the slot never captures a stale value.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    rs1_val = '0;
    if (rs1_in == 5'd0) begin
      rs1_val = '0;
    end else if (bus.reg_write && (bus.wr_reg == rs1_in)) begin
      rs1_val = bus.write_back_data;
    end else if (!out_of_range(rs1_in)) begin
      rs1_val = rf_word[rs1_in[IDXW-1:0]];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (rs2_in == 5'd0) begin
      rs2_val = '0;
    end else if (bus.reg_write && (bus.wr_reg == rs2_in)) begin
      rs2_val = bus.write_back_data;
    end else if (!out_of_range(rs2_in)) begin
      rs2_val = rf_word[rs2_in[IDXW-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Decode slot and handshake
  // ---------------------------------------------------------------------------
  logic            out_valid_reg;
  logic [XLEN-1:0] reg1_data_reg;
  logic [XLEN-1:0] reg2_data_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rs2_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] pc_reg;
  logic            write_back_reg;
  logic            mem_wr_reg;
  logic            mem_rd_reg;
  logic            alu_src_reg;
  logic [3:0]      alu_op_reg;
  logic [XLEN-1:0] immediate_reg;
  logic            illegal_reg;

  logic hazard;
  logic advance;
  logic load_slot;
  logic load_valid;

  // A load in the slot whose destination feeds the incoming instruction
  // cannot be satisfied by the bypass yet, so one bubble is inserted.
  assign hazard = out_valid_reg && mem_rd_reg && (rd_reg != 5'd0) &&
                  ((rd_reg == rs1_in) || (rs2_used && (rd_reg == rs2_in)));

  assign advance    = !out_valid_reg || bus.out_ready;
  // Flush loads the slot even under backpressure so the kill takes effect
  // on the very next edge.
  assign load_slot  = advance || bus.flush;
  assign load_valid = bus.in_valid && !hazard && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      reg1_data_reg  <= '0;
      reg2_data_reg  <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rd_reg         <= '0;
      pc_reg         <= '0;
      immediate_reg  <= '0;
      write_back_reg <= 1'b0;
      mem_wr_reg     <= 1'b0;
      mem_rd_reg     <= 1'b0;
      alu_src_reg    <= 1'b0;
      alu_op_reg     <= 4'b0000;
      illegal_reg    <= 1'b0;
    end else if (load_slot) begin
      out_valid_reg  <= load_valid;
      reg1_data_reg  <= rs1_val;
      reg2_data_reg  <= rs2_val;
      rs1_reg        <= rs1_in;
      rs2_reg        <= rs2_in;
      rd_reg         <= rd_in;
      pc_reg         <= bus.pc;
      immediate_reg  <= dec_imm;
      // Bubbles carry no control so execute can ignore out_valid safely.
      write_back_reg <= load_valid && dec_wb;
      mem_wr_reg     <= load_valid && dec_mw;
      mem_rd_reg     <= load_valid && dec_mr;
      alu_src_reg    <= load_valid && dec_as;
      alu_op_reg     <= load_valid ? dec_op : 4'b0000;
      illegal_reg    <= load_valid && dec_ill;
    end
  end

  assign bus.in_ready   = (advance && !hazard) || bus.flush;
  assign bus.out_valid  = out_valid_reg;
  assign bus.reg1_data  = reg1_data_reg;
  assign bus.reg2_data  = reg2_data_reg;
  assign bus.rs1        = rs1_reg;
  assign bus.rs2        = rs2_reg;
  assign bus.rd         = rd_reg;
  assign bus.pc_out     = pc_reg;
  assign bus.write_back = write_back_reg;
  assign bus.mem_wr     = mem_wr_reg;
  assign bus.mem_rd     = mem_rd_reg;
  assign bus.alu_src    = alu_src_reg;
  assign bus.alu_op     = alu_op_reg;
  assign bus.immediate  = immediate_reg;
  assign bus.illegal    = illegal_reg;

endmodule
